// File: rtl/merged_line_writer_pkg.sv
// rtl/merged_line_writer_pkg.sv - shared constants, FSM state encoding and sizing helpers for the line writer
package merged_line_writer_pkg;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_KEY_WIDTH  = 80;
  localparam int DEF_P          = 2;
  localparam int DEF_LINE_WIDTH = 512;
  localparam int DEF_ADDR_WIDTH = 32;

  // Max-key sentinel: an all-ones line sorts after every real record.
  localparam logic [DEF_LINE_WIDTH-1:0] PAD_LINE = {DEF_LINE_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int tuple_width(input int data_w, input int p);
    return data_w * p;
  endfunction

  function automatic int beats_of(input int line_w, input int tw);
    return line_w / tw;
  endfunction

endpackage

// File: rtl/merged_line_writer.sv
// rtl/merged_line_writer.sv - packs merger-tree output tuples into memory lines and issues line writes
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_start, i_base_addr, i_total  job start pulse, first line address, tuple count
//   i_data, i_empty, o_deq         upstream FIFO head, empty flag, pop strobe
//   o_wr_valid/addr/data, i_wr_ready  line write channel
//   o_busy, o_done, o_lines_written   job status
module merged_line_writer
  import merged_line_writer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
  parameter int P          = DEF_P,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_start,
  input  logic [ADDR_WIDTH-1:0]                  i_base_addr,
  input  logic [31:0]                            i_total,
  input  logic [tuple_width(DATA_WIDTH, P)-1:0]  i_data,
  input  logic                                   i_empty,
  output logic                                   o_deq,
  output logic                                   o_wr_valid,
  output logic [ADDR_WIDTH-1:0]                  o_wr_addr,
  output logic [LINE_WIDTH-1:0]                  o_wr_data,
  input  logic                                   i_wr_ready,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic [31:0]                            o_lines_written
);

  localparam int TW    = tuple_width(DATA_WIDTH, P);
  localparam int BEATS = beats_of(LINE_WIDTH, TW);
  localparam int BIW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Pad record: key field all-ones (max key), payload all-ones as well.
  localparam logic [DATA_WIDTH-1:0] PAD_REC =
    {{KEY_WIDTH{1'b1}}, {(DATA_WIDTH - KEY_WIDTH){1'b1}}};
  localparam logic [LINE_WIDTH-1:0] PAD_LN = {(LINE_WIDTH / DATA_WIDTH){PAD_REC}};

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   line_idx_q, line_idx_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]             left_q, left_d;
  logic [31:0]             lines_q, lines_d;
  logic [BIW-1:0]          beat_q, beat_d;
  logic [LINE_WIDTH-1:0]   asm_q, asm_d;
  logic [LINE_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_valid_q, wr_valid_d;
  logic                    done_q, done_d;

  logic                    last_beat, out_free, accept, deq, load;
  logic [LINE_WIDTH-1:0]   line_new;

  // Dequeue decision and the line that would be loaded this cycle.
  // The final tuple bypasses the assembly register straight into the output line.
  always_comb begin
    last_beat = (beat_q == BIW'(BEATS - 1)) || (left_q == 32'd1);
    out_free  = !wr_valid_q || i_wr_ready;
    accept    = wr_valid_q && i_wr_ready;
    deq       = (state_q == ST_FILL) && !i_empty && (left_q != 32'd0) &&
                (!last_beat || out_free);
    load      = deq && last_beat;
    line_new  = PAD_LN;
    for (int k = 0; k < BEATS; k++) begin
      if (BIW'(k) < beat_q)
        line_new[k*TW +: TW] = asm_q[k*TW +: TW];
      else if (BIW'(k) == beat_q)
        line_new[k*TW +: TW] = i_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    line_idx_d = line_idx_q;
    left_d     = left_q;
    lines_d    = lines_q + 32'(accept);
    beat_d     = beat_q;
    asm_d      = asm_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (accept)
      wr_valid_d = 1'b0;

    // A load on the same cycle as an accept overrides the drop of valid.
    if (deq) begin
      left_d = left_q - 32'd1;
      if (load) begin
        wr_valid_d = 1'b1;
        wr_addr_d  = base_q + line_idx_q;
        wr_data_d  = line_new;
        line_idx_d = line_idx_q + ADDR_WIDTH'(1);
        beat_d     = '0;
      end else begin
        for (int k = 0; k < BEATS; k++)
          if (BIW'(k) == beat_q)
            asm_d[k*TW +: TW] = i_data;
        beat_d = beat_q + BIW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          base_d     = i_base_addr;
          left_d     = i_total;
          lines_d    = '0;
          line_idx_d = '0;
          beat_d     = '0;
          state_d    = (i_total == 32'd0) ? ST_DONE : ST_FILL;
        end
      end
      // The last tuple is always a line's final beat, so DRAIN starts with a pending write.
      ST_FILL:  if (deq && (left_q == 32'd1)) state_d = ST_DRAIN;
      ST_DRAIN: if (accept) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      line_idx_q <= '0;
      wr_addr_q  <= '0;
      left_q     <= '0;
      lines_q    <= '0;
      beat_q     <= '0;
      asm_q      <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      line_idx_q <= line_idx_d;
      wr_addr_q  <= wr_addr_d;
      left_q     <= left_d;
      lines_q    <= lines_d;
      beat_q     <= beat_d;
      asm_q      <= asm_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      done_q     <= done_d;
    end
  end

  assign o_deq           = deq;
  assign o_wr_valid      = wr_valid_q;
  assign o_wr_addr       = wr_addr_q;
  assign o_wr_data       = wr_data_q;
  assign o_busy          = (state_q == ST_FILL) || (state_q == ST_DRAIN);
  assign o_done          = done_q;
  assign o_lines_written = lines_q;

endmodule

// File: tb/tb_merged_line_writer.sv
// tb/tb_merged_line_writer.sv - self-checking bench for merged_line_writer with a tuple-queue reference model
module tb_merged_line_writer;

  localparam int DW    = 128;
  localparam int PP    = 2;
  localparam int LW    = 512;
  localparam int TW    = DW * PP;
  localparam int BEATS = LW / TW;

  typedef logic [TW-1:0] tuple_t;
  typedef logic [LW-1:0] line_t;

  typedef struct {
    int          total;
    logic [31:0] base;
    int          emode;
    int          rmode;
    int          stall;
    int          exp_lines;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] total;
  tuple_t      data;
  logic        empty;
  logic        deq;
  logic        wr_valid;
  logic [31:0] wr_addr;
  line_t       wr_data;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic [31:0] lines_written;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  merged_line_writer #(
    .DATA_WIDTH(DW), .KEY_WIDTH(80), .P(PP), .LINE_WIDTH(LW), .ADDR_WIDTH(32)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_total(total), .i_data(data), .i_empty(empty), .o_deq(deq),
    .o_wr_valid(wr_valid), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_wr_ready(wr_ready), .o_busy(busy), .o_done(done),
    .o_lines_written(lines_written)
  );

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkl(input string nm, input line_t act, input line_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic tuple_t rnd_tuple();
    tuple_t t;
    for (int w = 0; w < TW / 32; w++) t[w*32 +: 32] = $urandom();
    return t;
  endfunction

  // emode: 0 never empty, 1 empty every other cycle, 2 random empty
  // rmode: 0 always ready, 1 random ready, 2 ready low for 'stall' cycles once the first line loads
  task automatic run_job(input int tot, input logic [31:0] base, input int emode,
                         input int rmode, input int stall, input int exp_lines);
    tuple_t      tq[$];
    line_t       el[$];
    line_t       ln;
    int          nlines, popped, loads, accepted, first_load;
    bit          mvalid, mdone, was_done, ml, ed, acc, ld;
    logic [31:0] ea;

    nlines = (tot + BEATS - 1) / BEATS;
    for (int i = 0; i < tot; i++) tq.push_back(rnd_tuple());
    for (int j = 0; j < nlines; j++) begin
      ln = '1;
      for (int k = 0; k < BEATS; k++)
        if (j * BEATS + k < tot) ln[k*TW +: TW] = tq[j*BEATS + k];
      el.push_back(ln);
    end

    popped = 0; loads = 0; accepted = 0; first_load = -1;
    mvalid = 1'b0; mdone = (tot == 0); was_done = 1'b0;

    @(negedge clk);
    start = 1'b1; base_addr = base; total = 32'(tot); empty = 1'b1; wr_ready = 1'b1;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (popped >= tot) empty = 1'($urandom_range(0, 1));
      else if (emode == 0) empty = 1'b0;
      else if (emode == 1) empty = ((cyc % 2) == 1);
      else empty = 1'($urandom_range(0, 1));
      data = (popped < tot) ? tq[popped] : rnd_tuple();
      if (first_load < 0 && mvalid) first_load = cyc;
      if (rmode == 0) wr_ready = 1'b1;
      else if (rmode == 1) wr_ready = 1'($urandom_range(0, 1));
      else wr_ready = (first_load < 0) || (cyc - first_load >= stall);
      #1;

      ml = ((popped % BEATS) == BEATS - 1) || (popped == tot - 1);
      ed = !empty && (popped < tot) && (!ml || !mvalid || wr_ready);
      chkb("deq", deq, ed);
      chkb("wr_valid", wr_valid, mvalid);
      if (mvalid) begin
        ea = base + 32'(loads - 1);
        chkw("wr_addr", wr_addr, ea);
        chkl("wr_data", wr_data, el[loads-1]);
      end
      chkb("done", done, mdone);
      chkb("busy", busy, accepted < nlines);
      chkw("lines_written", lines_written, 32'(accepted));

      was_done = mdone;
      acc = mvalid && wr_ready;
      ld  = ed && ml;
      if (ed) popped++;
      if (ld) loads++;
      if (acc) accepted++;
      mvalid = ld ? 1'b1 : (acc ? 1'b0 : mvalid);
      mdone  = acc && (accepted == nlines);
      if (was_done) break;
    end

    if (!was_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL job_timeout: total=%0d no done within budget", tot);
    end

    @(negedge clk);
    empty = 1'b1;
    #1;
    chkb("done_one_cycle", done, 1'b0);
    chkb("busy_after_done", busy, 1'b0);
    chkw("lines_final", lines_written, 32'(exp_lines));
  endtask

  vec_t vecs[8];

  initial begin
    bit found;

    vecs[0] = '{4, 32'h0000_0100, 0, 0, 0, 2};
    vecs[1] = '{3, 32'h0000_0200, 0, 0, 0, 2};
    vecs[2] = '{4, 32'h0000_0300, 0, 2, 10, 2};
    vecs[3] = '{6, 32'h0000_0400, 1, 0, 0, 3};
    vecs[4] = '{0, 32'h0000_0500, 0, 0, 0, 0};
    vecs[5] = '{4, 32'hFFFF_FFFF, 0, 0, 0, 2};
    vecs[6] = '{1, 32'h0000_0600, 2, 1, 0, 1};
    vecs[7] = '{9, 32'h0000_0700, 2, 1, 0, 5};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; total = '0;
    data = '1; empty = 1'b0; wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chkb("rst_wr_valid", wr_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_deq", deq, 1'b0);
    chkw("rst_lines", lines_written, 32'd0);
    chkw("rst_addr", wr_addr, 32'd0);
    chkl("rst_data", wr_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    empty = 1'b1;

    for (int v = 0; v < 8; v++)
      run_job(vecs[v].total, vecs[v].base, vecs[v].emode, vecs[v].rmode,
              vecs[v].stall, vecs[v].exp_lines);

    for (int r = 0; r < 6; r++) begin
      int t;
      t = $urandom_range(0, 9);
      run_job(t, $urandom(), $urandom_range(0, 2), 1, 0, (t + BEATS - 1) / BEATS);
    end

    // Reset while the final line waits in the output register.
    @(negedge clk);
    start = 1'b1; base_addr = 32'h40; total = 32'd2; empty = 1'b1; wr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; empty = 1'b0; data = rnd_tuple();
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (wr_valid && busy) begin
        found = 1'b1;
        break;
      end
    end
    chkb("drain_reached", found, 1'b1);
    rst_n = 1'b0;
    empty = 1'b1;
    @(negedge clk);
    #1;
    chkb("midrst_wr_valid", wr_valid, 1'b0);
    chkb("midrst_busy", busy, 1'b0);
    chkw("midrst_lines", lines_written, 32'd0);
    chkl("midrst_data", wr_data, '0);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    run_job(4, 32'h0000_0800, 0, 0, 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
